// File: rtl/axi_lite_seq_pkg.sv
// axi_lite_seq_pkg: shared FSM state and AXI response encodings for the sequencer
package axi_lite_seq_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp == RESP_SLVERR || resp == RESP_DECERR;
    endfunction

endpackage

// File: rtl/axi_lite_seq_master.sv
// axi_lite_seq_master: issues COUNT AXI-lite reads or writes at base+i*stride and tallies the responses
module axi_lite_seq_master
    import axi_lite_seq_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    write_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH-1:0]   stride_i,
    input  logic [CNT_WIDTH-1:0]    count_i,
    input  logic [DATA_WIDTH-1:0]   wdata_seed_i,
    input  logic [DATA_WIDTH-1:0]   wdata_incr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [CNT_WIDTH-1:0]    err_count_o,
    output logic [CNT_WIDTH-1:0]    rsp_count_o,
    output logic [DATA_WIDTH-1:0]   rdata_sum_o,
    output logic [DATA_WIDTH-1:0]   last_rdata_o,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    input  logic [1:0]              b_resp_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_valid_i,
    output logic                    r_ready_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

    state_e                  state_q, state_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, stride_q, stride_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d, incr_q, incr_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d, idx_q, idx_d;
    logic [OW-1:0]           outs_q, outs_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    error_q, error_d;
    logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d, rsp_cnt_q, rsp_cnt_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d, last_q, last_d;

    logic slot, aw_hs, w_hs, ar_hs, b_hs, r_hs, issued, rsp, rsp_err, last;

    // A slot is open only while issuing below the in-flight limit; once a valid rises the
    // limit cannot tighten before that issue completes, so valids stay up until ready.
    assign slot       = state_q == ST_ISSUE && outs_q < MAX_O;
    assign aw_valid_o = slot && write_q && !aw_done_q;
    assign w_valid_o  = slot && write_q && !w_done_q;
    assign ar_valid_o = slot && !write_q;
    assign aw_addr_o  = addr_q;
    assign ar_addr_o  = addr_q;
    assign w_data_o   = data_q;
    assign w_strb_o   = '1;
    assign busy_o     = state_q == ST_ISSUE || state_q == ST_DRAIN;
    assign done_o     = state_q == ST_DONE;
    assign b_ready_o  = busy_o && write_q;
    assign r_ready_o  = busy_o && !write_q;
    assign error_o      = error_q;
    assign err_count_o  = err_cnt_q;
    assign rsp_count_o  = rsp_cnt_q;
    assign rdata_sum_o  = sum_q;
    assign last_rdata_o = last_q;

    assign aw_hs   = aw_valid_o && aw_ready_i;
    assign w_hs    = w_valid_o && w_ready_i;
    assign ar_hs   = ar_valid_o && ar_ready_i;
    assign b_hs    = b_valid_i && b_ready_o;
    assign r_hs    = r_valid_i && r_ready_o;
    assign issued  = write_q ? slot && (aw_done_q || aw_hs) && (w_done_q || w_hs) : ar_hs;
    assign rsp     = b_hs || r_hs;
    assign rsp_err = (b_hs && resp_is_err(b_resp_i)) || (r_hs && resp_is_err(r_resp_i));
    assign last    = idx_q == count_q - CNT_WIDTH'(1);

    // Next-state: issue bookkeeping, response accounting, FSM transitions and start-time latching.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        data_d    = data_q;
        incr_d    = incr_q;
        count_d   = count_q;
        idx_d     = idx_q;
        outs_d    = outs_q + OW'(issued) - OW'(rsp);
        aw_done_d = issued ? 1'b0 : aw_done_q || aw_hs;
        w_done_d  = issued ? 1'b0 : w_done_q || w_hs;
        error_d   = error_q || rsp_err;
        err_cnt_d = err_cnt_q + CNT_WIDTH'(rsp_err);
        rsp_cnt_d = rsp_cnt_q + CNT_WIDTH'(rsp);
        sum_d     = r_hs ? sum_q + r_data_i : sum_q;
        last_d    = r_hs ? r_data_i : last_q;
        if (issued) begin
            idx_d  = idx_q + CNT_WIDTH'(1);
            addr_d = addr_q + stride_q;
            data_d = data_q + incr_q;
        end
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d   = count_i != '0 ? ST_ISSUE : ST_DONE;
                write_d   = write_i;
                addr_d    = base_addr_i;
                stride_d  = stride_i;
                data_d    = wdata_seed_i;
                incr_d    = wdata_incr_i;
                count_d   = count_i;
                idx_d     = '0;
                outs_d    = '0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                error_d   = 1'b0;
                err_cnt_d = '0;
                rsp_cnt_d = '0;
                sum_d     = '0;
                last_d    = '0;
            end
            ST_ISSUE: state_d = issued && last ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_d = outs_q == '0 ? ST_DONE : ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any sequence and clears every output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            stride_q  <= '0;
            data_q    <= '0;
            incr_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            outs_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            rsp_cnt_q <= '0;
            sum_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            data_q    <= data_d;
            incr_q    <= incr_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            outs_q    <= outs_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            sum_q     <= sum_d;
            last_q    <= last_d;
        end
    end

endmodule
